// File: rtl/risc_regfile_pkg.sv
// Shared types and constants for the multi-read-port register file.
// Optional write-first bypass is selected with the RISC_REGFILE_BYPASS_EN macro.
package risc_regfile_pkg;

  // Two-state controller: CLEAR sweeps every entry to zero, IDLE serves reads/writes.
  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  // Upper bound on the number of read ports this file is built for.
  localparam int RF_MAX_NRD = 4;

  // Number of registers addressed by an addr_w-bit register index.
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/risc_regfile_rdport.sv
// One registered read port of the register file.
// Selects the addressed entry, applies the R0-reads-zero mask and, when
// RISC_REGFILE_BYPASS_EN is defined, forwards a same-cycle write (write-first).
// Without the macro a same-cycle write is not seen until the next read (read-first).
module risc_regfile_rdport
  import risc_regfile_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int R0_ZERO = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [DATA_W-1:0] mem_i [rf_depth(ADDR_W)],
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rs_data_o
);

  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rs_data_d;
  logic              r0_hit;

  // Register 0 masking only exists when the hardwired-zero option is on.
  assign r0_hit = (R0_ZERO != 0) && (rs_addr_i == '0);

`ifndef RISC_REGFILE_BYPASS_EN
  // Write-port inputs only matter for forwarding; keep them visibly consumed.
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

  // Next read value: array entry, optionally overridden by the incoming write, then R0 mask.
  always_comb begin
    rs_data_d = mem_i[rs_addr_i];
`ifdef RISC_REGFILE_BYPASS_EN
    if (wr_en_i && (wr_addr_i == rs_addr_i)) begin
      rs_data_d = wr_data_i;
    end
`endif
    if (r0_hit) begin
      rs_data_d = '0;
    end
  end

  // Output register: forced to zero during reset and while the clear sweep runs.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rs_data_q <= '0;
    end else begin
      rs_data_q <= rs_data_d;
    end
  end

  assign rs_data_o = rs_data_q;

endmodule

// File: rtl/risc_regfile_mp.sv
// Parametrised register file: NRD registered read ports, one write port,
// a hardware clear sweep after every reset and optional R0-hardwired-zero.
// Read data appears one cycle after the address. busy is high while the
// sweep runs and decode must stall. Same-cycle write/read forwarding is
// enabled by defining RISC_REGFILE_BYPASS_EN (default: read-first).
// dbg_state_o mirrors the controller state (1 = CLEAR, 0 = IDLE).
module risc_regfile_mp
  import risc_regfile_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int NRD     = 2,
  parameter int R0_ZERO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rs_addr,
  output logic [NRD*DATA_W-1:0] rs_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_write,
  input  logic [DATA_W-1:0]     rd,
  output logic                  busy,
  output logic                  dbg_state_o
);

  localparam int                DEPTH    = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

  if ((NRD < 1) || (NRD > RF_MAX_NRD)) begin : g_bad_nrd
    $error("risc_regfile_mp: NRD must be in 1..%0d", RF_MAX_NRD);
  end

  rf_state_t         state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [ADDR_W-1:0] clr_ptr_d;
  logic              busy_q;
  logic              clearing;
  logic              wr_to_r0;
  logic              wr_en;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign clearing  = (state_q == RF_CLEAR);
  assign clr_ptr_d = clr_ptr_q + ADDR_W'(1);

  // Writes only land in IDLE; a write to R0 is discarded when R0 is hardwired.
  assign wr_to_r0 = (R0_ZERO != 0) && (rd_addr == '0);
  assign wr_en    = rd_write && (state_q == RF_IDLE) && !wr_to_r0;

  // Controller: reset restarts the sweep; the sweep ends by compare on the last index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          if (clr_ptr_q == LAST_PTR) begin
            state_q   <= RF_IDLE;
            clr_ptr_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            clr_ptr_q <= clr_ptr_d;
          end
        end
        default: begin
          state_q <= RF_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: the sweep zeroes one entry per cycle, otherwise the write port updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_en) begin
        mem_q[rd_addr] <= rd;
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    risc_regfile_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .R0_ZERO (R0_ZERO)
    ) u_rdport (
      .clk_i     (clk),
      .rst_i     (rst),
      .clear_i   (clearing),
      .rs_addr_i (rs_addr[g*ADDR_W +: ADDR_W]),
      .mem_i     (mem_q),
      .wr_en_i   (wr_en),
      .wr_addr_i (rd_addr),
      .wr_data_i (rd),
      .rs_data_o (rs_data[g*DATA_W +: DATA_W])
    );
  end

  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_risc_regfile_mp.sv
// Directed bench for risc_regfile_mp: a default 16x8, 2-read-port file and a
// second 8x8, 4-read-port file with R0 hardwired to zero.
module tb_risc_regfile_mp;

`ifdef RISC_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // main DUT: DATA_W=8 ADDR_W=4 NRD=2 R0_ZERO=0
  logic        rst;
  logic [7:0]  rs_addr;
  logic [15:0] rs_data;
  logic [3:0]  rd_addr;
  logic        rd_write;
  logic [7:0]  rd;
  logic        busy;
  logic        state;

  // second DUT: DATA_W=8 ADDR_W=3 NRD=4 R0_ZERO=1
  logic        z_rst;
  logic [11:0] z_rs_addr;
  logic [31:0] z_rs_data;
  logic [2:0]  z_rd_addr;
  logic        z_rd_write;
  logic [7:0]  z_rd;
  logic        z_busy;
  logic        z_state;

  risc_regfile_mp #(.DATA_W(8), .ADDR_W(4), .NRD(2), .R0_ZERO(0)) dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data),
    .rd_addr(rd_addr), .rd_write(rd_write), .rd(rd), .busy(busy),
    .dbg_state_o(state)
  );

  risc_regfile_mp #(.DATA_W(8), .ADDR_W(3), .NRD(4), .R0_ZERO(1)) dut_z (
    .clk(clk), .rst(z_rst), .rs_addr(z_rs_addr), .rs_data(z_rs_data),
    .rd_addr(z_rd_addr), .rd_write(z_rd_write), .rd(z_rd), .busy(z_busy),
    .dbg_state_o(z_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    logic [3:0] a;
    a = 4'(i);
    return {a, ~a};
  endfunction

  // ---------------- driver tasks (main DUT) ----------------
  // All tasks start and end on a falling edge; inputs change there, outputs are sampled there.
  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    rd_write = 1'b1;
    rd_addr  = a;
    rd       = d;
    @(negedge clk);
    rd_write = 1'b0;
  endtask

  task automatic read2(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [7:0] e0, input logic [7:0] e1);
    rs_addr = {a1, a0};
    exp_q.push_back({16'h0, e1, e0});
    @(negedge clk);
    check_eq(tag, {16'h0, rs_data}, exp_q.pop_front());
  endtask

  // Called on the falling edge where rst has just dropped; returns cycles until busy falls.
  task automatic run_sweep(input string tag, input bit inject, input int rst_at, output int len);
    int n;
    int guard;
    bit restarted;
    n = 0;
    guard = 0;
    restarted = 1'b0;
    while (guard < 100) begin
      guard++;
      rd_write = 1'b0;
      if (inject && n == 3) begin
        rd_write = 1'b1; rd_addr = 4'd7; rd = 8'hFF;
      end
      if (inject && n == 11) begin
        rd_write = 1'b1; rd_addr = 4'd1; rd = 8'hEE;
      end
      if (!restarted && rst_at > 0 && n == rst_at - 1) begin
        rst = 1'b1;
        restarted = 1'b1;
      end
      @(negedge clk);
      if (rst) begin
        rst = 1'b0;
        n = 0;
        check_eq({tag, "_rst_busy"}, {31'h0, busy}, 32'h1);
        continue;
      end
      n++;
      check_eq({tag, "_zero"}, {16'h0, rs_data}, 32'h0);
      if (!busy) break;
    end
    rd_write = 1'b0;
    check_eq({tag, "_done"}, {31'h0, busy}, 32'h0);
    len = n;
  endtask

  // ---------------- driver tasks (R0_ZERO DUT) ----------------
  task automatic z_write(input logic [2:0] a, input logic [7:0] d);
    z_rd_write = 1'b1;
    z_rd_addr  = a;
    z_rd       = d;
    @(negedge clk);
    z_rd_write = 1'b0;
  endtask

  task automatic z_read4(input string tag, input logic [2:0] a0, input logic [2:0] a1,
                         input logic [2:0] a2, input logic [2:0] a3, input logic [31:0] e);
    z_rs_addr = {a3, a2, a1, a0};
    exp_q.push_back(e);
    @(negedge clk);
    check_eq(tag, z_rs_data, exp_q.pop_front());
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- stimulus ----------------
  initial begin
    int len;
    logic [7:0] old_v;
    rst = 1'b1; rs_addr = '0; rd_addr = '0; rd_write = 1'b0; rd = '0;
    z_rst = 1'b1; z_rs_addr = '0; z_rd_addr = '0; z_rd_write = 1'b0; z_rd = '0;

    // 1: reset state, then sweep length and zero read data throughout
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'h0, busy}, 32'h1);
    check_eq("rst_rs_data", {16'h0, rs_data}, 32'h0);
    check_eq("rst_state", {31'h0, state}, 32'h1);
    check_eq("z_rst_busy", {31'h0, z_busy}, 32'h1);
    rst = 1'b0;
    rs_addr = {4'd1, 4'd7};
    run_sweep("sweep0", 1'b0, 0, len);
    check_eq("sweep0_len", len, 16);
    check_eq("idle_state", {31'h0, state}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      read2($sformatf("clr_r%0d", i), 4'(i), 4'(15 - i), 8'h00, 8'h00);
    end

    // 2: write then read on both ports
    write_reg(4'd5, 8'hA5);
    read2("wr_r5", 4'd5, 4'd5, 8'hA5, 8'hA5);

    // address decode: distinct pattern in every register
    for (int i = 0; i < 16; i++) write_reg(4'(i), pat(i));
    for (int i = 0; i < 16; i++) begin
      read2($sformatf("scan_r%0d", i), 4'(i), 4'(15 - i), pat(i), pat(15 - i));
    end

    // 3: same-cycle write and read of r3 (port 1 reads unrelated r4)
    write_reg(4'd3, 8'h11);
    rd_write = 1'b1; rd_addr = 4'd3; rd = 8'h3C;
    old_v = BYP ? 8'h3C : 8'h11;
    read2("collide_r3", 4'd3, 4'd4, old_v, pat(4));
    rd_write = 1'b0;
    read2("after_collide_r3", 4'd3, 4'd3, 8'h3C, 8'h3C);

    // 4: reset in IDLE clears contents; writes during the sweep are dropped
    write_reg(4'd7, 8'h77);
    write_reg(4'd1, 8'h11);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_rst_busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    run_sweep("sweep_wr", 1'b1, 0, len);
    check_eq("sweep_wr_len", len, 16);
    read2("drop_r7_r1", 4'd7, 4'd1, 8'h00, 8'h00);

    // 5: reset pulse at sweep cycle 9 restarts the full sweep
    write_reg(4'd9, 8'h99);
    write_reg(4'd15, 8'hF0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_sweep("sweep_mid", 1'b0, 9, len);
    check_eq("sweep_mid_len", len, 16);
    read2("mid_r9_r15", 4'd9, 4'd15, 8'h00, 8'h00);
    write_reg(4'd2, 8'h2D);
    read2("post_mid_wr", 4'd2, 4'd9, 8'h2D, 8'h00);

    // 6: R0_ZERO DUT, 4 ports, 8-entry sweep
    z_rst = 1'b0;
    len = 0;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      len++;
      check_eq("z_sweep_zero", z_rs_data, 32'h0);
      if (!z_busy) break;
    end
    check_eq("z_sweep_len", len, 8);
    z_write(3'd0, 8'h55);
    z_read4("z_r0_rd", 3'd0, 3'd0, 3'd0, 3'd0, 32'h0);
    z_write(3'd2, 8'h22);
    z_write(3'd5, 8'h50);
    z_read4("z_mix", 3'd2, 3'd5, 3'd0, 3'd2, {8'h22, 8'h00, 8'h50, 8'h22});
    z_rd_write = 1'b1; z_rd_addr = 3'd0; z_rd = 8'h55;
    z_read4("z_r0_same", 3'd0, 3'd0, 3'd0, 3'd0, 32'h0);
    z_rd_write = 1'b1; z_rd_addr = 3'd5; z_rd = 8'h5C;
    old_v = BYP ? 8'h5C : 8'h50;
    z_read4("z_collide_r5", 3'd5, 3'd5, 3'd0, 3'd6, {8'h00, 8'h00, old_v, old_v});
    z_rd_write = 1'b0;
    z_read4("z_after_r5", 3'd5, 3'd5, 3'd5, 3'd5, {4{8'h5C}});
    z_read4("z_keep", 3'd2, 3'd0, 3'd7, 3'd5, {8'h5C, 8'h00, 8'h00, 8'h22});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
